// File: rtl/sram_mem_ctrl_if.sv
// rtl/sram_mem_ctrl_if.sv - load/store request/response bundle between EXE stage and SRAM controller
interface sram_mem_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output rd_en, output wr_en, output address, output write_data,
                    input read_data, input ready);
    modport slave  (input rd_en, input wr_en, input address, input write_data,
                    output read_data, output ready);
endinterface

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - 32-bit load/store controller for a 16-bit asynchronous SRAM
module sram_mem_ctrl #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst,
    sram_mem_ctrl_if.slave   bus,
    output logic [17:0]      sram_addr,
    output logic [15:0]      sram_dq_out,
    input  logic [15:0]      sram_dq_in,
    output logic             sram_dq_oe,
    output logic             sram_we_n
);
    localparam int              CW   = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0]   HOLD = CW'(WAIT_CYCLES - 2);
    localparam logic [31:0]     BASE = 32'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t        state, next_state;
    logic [CW-1:0] counter;
    logic          op_write;
    logic [16:0]   word_idx;
    logic [31:0]   wdata;
    logic [15:0]   capture_lo;
    logic [31:0]   read_data_r;
    logic          req;
    logic [16:0]   idx_in;

    assign req       = bus.rd_en | bus.wr_en;
    assign idx_in    = 17'((bus.address - BASE) >> 2);
    assign bus.ready = ((state == IDLE) && !req) || (state == DONE);
    assign bus.read_data = read_data_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = LOW;
            LOW:     if (counter == LAST) next_state = HIGH;
            HIGH:    if (counter == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter <= '0;
        end else if ((state == LOW || state == HIGH) && counter != LAST) begin
            counter <= counter + CW'(1);
        end else begin
            counter <= '0;
        end
    end

    // SRAM pins are registered so each phase's values appear on its first cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_write    <= 1'b0;
            word_idx    <= '0;
            wdata       <= '0;
            capture_lo  <= '0;
            read_data_r <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req) begin
                    op_write   <= bus.wr_en;
                    word_idx   <= idx_in;
                    wdata      <= bus.write_data;
                    sram_addr  <= {idx_in, 1'b0};
                    sram_dq_oe <= bus.wr_en;
                    sram_we_n  <= !bus.wr_en;
                    if (bus.wr_en) sram_dq_out <= bus.write_data[15:0];
                end
                LOW: begin
                    if (counter == LAST) begin
                        if (!op_write) capture_lo <= sram_dq_in;
                        sram_addr  <= {word_idx, 1'b1};
                        sram_we_n  <= !op_write;
                        if (op_write) sram_dq_out <= wdata[31:16];
                    end else if (counter == HOLD) begin
                        sram_we_n <= 1'b1;
                    end
                end
                HIGH: begin
                    if (counter == LAST) begin
                        if (!op_write) read_data_r <= {sram_dq_in, capture_lo};
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else if (counter == HOLD) begin
                        sram_we_n <= 1'b1;
                    end
                end
                default: begin
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Memory-side responder for the load/store path of the EXE stage.
- Takes the ALU result as a byte address, the store value and the MEM read/write enables, and performs 32-bit word accesses on an external 16-bit asynchronous SRAM.
- Each word is split into two half-word phases, each lasting WAIT_CYCLES clocks.
- Drives ready low while an access is in flight; the hazard/freeze logic uses ready to stall every pipeline register.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 5: clocks per half-word phase. Minimum 2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rd_en  input  1  load request (MEM_R_EN)
- wr_en  input  1  store request (MEM_W_EN)
- address  input  32  byte address (ALU res)
- write_data  input  32  store data (Val_Rm)
- read_data  output  32  loaded word
- ready  output  1  1 = no access pending or access completing this cycle; 0 = stall pipeline
- sram_addr  output  18  SRAM half-word address
- sram_dq_out  output  16  data driven to SRAM
- sram_dq_in  input  16  data returned from SRAM
- sram_dq_oe  output  1  1 = controller drives the DQ bus
- sram_we_n  output  1  SRAM write strobe, active-low

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - A reset mid-operation abandons the access. A half-completed write may leave only the low half-word written; this is accepted.
- Address map:
  - word_idx = (address - BASE_ADDR) >> 2, 32-bit subtraction, truncated to 17 bits.
  - address[1:0] ignored. No range check; out-of-range addresses wrap modulo 2^17 words.
  - Low half-word at sram_addr = {word_idx,1'b0} (bits 15:0). High half-word at {word_idx,1'b1} (bits 31:16).
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if rd_en|wr_en, latch word_idx, write_data and op (write if wr_en, else read), clear the counter, go to LOW. If both enables are high, write has priority.
  - LOW: counter counts 0..WAIT_CYCLES-1. At WAIT_CYCLES-1, clear the counter and go to HIGH.
  - HIGH: same counting. At WAIT_CYCLES-1, go to DONE.
  - DONE: one cycle, then unconditionally IDLE.
- Inputs are sampled only in IDLE. Changes during LOW/HIGH/DONE are ignored.
- ready = (IDLE and !(rd_en|wr_en)) or DONE. Combinational from state and the enables.
- Latency: request present in IDLE at cycle 0 → LOW in cycles 1..W → HIGH in cycles W+1..2W → DONE (ready=1) in cycle 2W+1. With the default W=5, ready rises in cycle 11.
- The pipeline advances on the DONE cycle. The next instruction's request is evaluated in the following IDLE cycle, so back-to-back accesses are separated by exactly one IDLE cycle.
- SRAM signalling during LOW/HIGH:
  - sram_addr holds the phase address for the whole phase.
  - Write:
    - sram_dq_oe=1 for the whole phase.
    - sram_dq_out = latched half-word.
    - sram_we_n=0 for counter 0..W-2, and 1 at counter W-1 (address/data hold cycle).
  - Read:
    - sram_dq_oe=0, sram_we_n=1.
    - sram_dq_in sampled at counter W-1 into the matching half of a capture register.
- In IDLE/DONE: sram_we_n=1, sram_dq_oe=0. sram_addr and sram_dq_out keep their last value.
- read_data:
  - Updated at the DONE cycle of a read: it shows the full assembled word in cycle 2W+1.
  - Held unchanged through writes and idle time until the next read completes.
- Counter width is clog2(WAIT_CYCLES) bits.

Test Plan:
1. Write then read (W=5): write 0xDEADBEEF to address 1024. Required:
   - sram_addr=0 with dq_out 0xBEEF, then sram_addr=1 with dq_out 0xDEAD.
   - ready=0 during cycles 1–10 and 1 at cycle 11.
   - The following read of 1024, with the SRAM model returning the stored halves, gives read_data=0xDEADBEEF at cycle 11 after the read request.
2. Address mapping and strobe timing: store to 1044.
   - sram_addr=10 then 11.
   - Misaligned 1046 also maps to 10/11.
   - sram_we_n is low for exactly 4 of 5 cycles in each phase.
3. Simultaneous enables: rd_en=wr_en=1 at 1028 with data 0x12345678 → write performed (sram_dq_oe=1, addresses 2/3); read_data unchanged.
4. Back-to-back: read 1024 then read 1028, with the enables held through ready. Required:
   - Second access starts after one IDLE cycle.
   - Total 24 cycles from first request to second DONE.
   - read_data changes only at each DONE.
5. Reset mid-write: assert rst=0 during the HIGH phase. Required:
   - sram_we_n=1, sram_dq_oe=0 and read_data=0 immediately, without waiting for a clock edge.
   - After release, ready=1 with no request pending.
6. WAIT_CYCLES=2: a read completes with ready=1 at cycle 5; sram_we_n stays 1 throughout the read.
